// File: rtl/display_pkg.sv
// Shared sizing defaults and FSM encoding for the display register bank and
// other frame-synchronised blocks.
package display_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } state_e;

endpackage

// File: rtl/vsync_edge_detect.sv
// Leading-edge detector for VSync; polarity is a parameter so any
// frame-synchronised block can reuse it.
module vsync_edge_detect #(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_vs_rise
);

  logic w_vs_act;
  logic r_vs_act_q;

  assign w_vs_act = (i_vsync == ~ACT_LOW);

  // Reset to the inactive level so a VSync already active at reset release
  // still counts as a leading edge on the first cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_act_q <= 1'b0;
    end else begin
      r_vs_act_q <= w_vs_act;
    end
  end

  assign o_vs_rise = w_vs_act & ~r_vs_act_q;

endmodule

// File: rtl/display_mem_bank.sv
// Double-buffered display register bank: producer fills the shadow bank,
// which is published to the front bank only on a VSync leading edge.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no commit queued; writes accepted
//   ST_PENDING | commit queued, waiting for VSync leading edge; writes ok
//   ST_COPY    | copying shadow->front one entry per cycle; writes held
module display_mem_bank
  import display_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter bit VSYNC_ACT_LOW = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_commit,
  output logic              o_commit_pending,
  output logic              o_commit_done,
  input  logic              i_vsync,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] o_mem_data
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_req_q;
  logic              r_commit_done;
  logic [DATA_W-1:0] r_front  [DEPTH];
  logic [DATA_W-1:0] r_shadow [DEPTH];

  logic w_vs_rise;
  logic w_in_copy;
  logic w_copy_last;
  logic w_wr_ready;
  logic w_commit_pending;
  logic w_wr_fire;

  vsync_edge_detect #(
    .ACT_LOW (VSYNC_ACT_LOW)
  ) u_vsync_edge (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_vsync   (i_vsync),
    .o_vs_rise (w_vs_rise)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_commit) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (w_vs_rise) w_state_nxt = ST_COPY;
      end
      ST_COPY: begin
        // A commit seen on the final copy cycle is queued, not lost.
        if (w_copy_last) w_state_nxt = (r_req_q | i_commit) ? ST_PENDING : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_copy        = 1'b0;
    w_wr_ready       = 1'b1;
    w_commit_pending = 1'b0;
    case (r_state)
      ST_PENDING: begin
        w_commit_pending = 1'b1;
      end
      ST_COPY: begin
        w_in_copy        = 1'b1;
        w_wr_ready       = 1'b0;
        w_commit_pending = 1'b1;
      end
      default: begin
        w_in_copy        = 1'b0;
      end
    endcase
  end

  assign w_copy_last = w_in_copy & (r_idx == IDX_LAST);
  assign w_wr_fire   = i_wr_en & w_wr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx         <= '0;
      r_req_q       <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_copy_last;
      if (w_in_copy) begin
        r_idx <= r_idx + 1'b1;
      end else begin
        r_idx <= '0;
      end
      if (!w_in_copy || w_copy_last) begin
        r_req_q <= 1'b0;
      end else if (i_commit) begin
        r_req_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= '0;
    end else if (w_wr_fire) begin
      r_shadow[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_front[i] <= '0;
    end else if (w_in_copy) begin
      r_front[r_idx] <= r_shadow[r_idx];
    end
  end

  assign o_mem_data       = r_front[i_mem_addr];
  assign o_wr_ready       = w_wr_ready;
  assign o_commit_pending = w_commit_pending;
  assign o_commit_done    = r_commit_done;

endmodule

// File: doc/display_mem_bank.md
Name: display_mem_bank

Overview:
- Double-buffered 16x8 display register bank, directly upstream of ControlVGACentral.
- The producer (the data-acquisition/format FSM) writes a complete frame of display bytes into a shadow bank, then requests a commit.
- The block copies shadow to front bank only during vertical sync, so the VGA controller never scans a half-updated frame.
- The front bank drives the controller's MemDataIN from its MemAddrOut.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W = 16 entries.
- DATA_W, 8, entry width.
- VSYNC_ACT_LOW, 1, 1 = VSync active level is 0; 0 = active level is 1.

Ports:
- CLK  in  1  system clock, same clock as ControlVGACentral.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- WrEn  in  1  producer write strobe.
- WrAddr  in  ADDR_W  shadow-bank write address.
- WrData  in  DATA_W  shadow-bank write data.
- WrReady  out  1  write accepted this cycle when WrEn && WrReady.
- Commit  in  1  single-cycle request to publish the shadow bank.
- CommitPending  out  1  a commit is queued or in progress.
- CommitDone  out  1  one-cycle pulse when the front bank has been updated.
- VSync  in  1  VSync from ControlVGACentral (same clock domain).
- MemAddrIn  in  ADDR_W  read address from ControlVGACentral.
- MemDataOut  out  DATA_W  front[MemAddrIn] to ControlVGACentral.

Behaviour:
- Reset (RESET=0, async):
  - all front/shadow entries = 0, so MemDataOut = 0.
  - WrReady = 1, CommitPending = 0, CommitDone = 0.
  - state = IDLE, copy counter = 0, edge register = inactive level.
  - Reset asserted mid-COPY aborts the copy; no partial state survives.
- Read path: MemDataOut = front[MemAddrIn], combinational, zero latency. It is never stalled, whatever the state.
- Write path: on a rising CLK with WrEn && WrReady, shadow[WrAddr] <= WrData. Writes with WrReady=0 are dropped silently; the producer must hold them.
- VSync edge: vs_act = (VSync == !VSYNC_ACT_LOW). Register vs_act each cycle. vs_rise = vs_act && !vs_act_q.
- FSM states IDLE, PENDING, COPY:
  - IDLE: on Commit, go to PENDING. A write in the same cycle as Commit is included in the commit.
  - PENDING: on vs_rise, go to COPY with idx = 0. Writes are still accepted and are included in the copy. Commit here is ignored, since a commit is already queued.
  - COPY: each cycle front[idx] <= shadow[idx] and idx++. On idx == DEPTH-1:
    - CommitDone = 1 for that cycle's following clock;
    - next state = PENDING if a Commit arrived during COPY (latched in req_q), else IDLE.
  - COPY length is exactly DEPTH cycles (16), far shorter than the VSync pulse, so the whole update happens in blanking.
- WrReady = 0 only in COPY, so the shadow stays stable while being copied.
- CommitPending = 1 in PENDING and COPY.
- vs_rise while in IDLE or COPY is ignored. A commit never starts mid-frame, even if VSync is already active when Commit arrives; it waits for the next leading edge.
- Address wrap: idx is ADDR_W bits and is reset to 0 on COPY entry. No wrap into a second pass.
- Width rules: no arithmetic on data; addresses are unsigned with no out-of-range case (DEPTH = 2**ADDR_W).

Decomposition:
- Package display_pkg holds:
  - ADDR_W/DATA_W/DEPTH defaults;
  - state encoding ST_IDLE=2'd0, ST_PENDING=2'd1, ST_COPY=2'd2.
- One sub-module, vsync_edge_detect (VSync, VSYNC_ACT_LOW -> vs_rise), reusable by other frame-synchronised blocks.
- The two banks are plain register arrays inside display_mem_bank.

Test Plan:
- Reset release, MemAddrIn swept 0..15 -> MemDataOut = 0 for every address; WrReady = 1; CommitPending = 0.
- Write shadow 0..9 = 0,30,15,3,4,3,15,3,50,3 with no Commit, then VSync pulses -> MemDataOut stays 0 at all addresses.
- Same writes, Commit, then VSync falling edge (active-low):
  - CommitPending goes 1 the cycle after Commit;
  - COPY starts 1 cycle after the edge, and WrReady = 0 for exactly 16 cycles;
  - CommitDone pulses once, then front[1] = 30 and front[8] = 50.
- Commit during COPY -> after CommitDone, state returns to PENDING. A write of 0xAA to address 2 is held off while WrReady=0, then accepted. It appears on MemDataOut(addr 2) only after the next VSync edge copy.
- Commit issued while VSync is already active -> no copy in this pulse; the copy occurs on the next leading edge (about 16.7 ms later at 60 Hz).
- RESET driven low during the 8th COPY cycle -> immediately all outputs are at reset values and front = 0. After release, WrReady = 1 and state = IDLE.
